// File: rtl/brightness_ramp_controller_pkg.sv
`default_nettype none
// ============================================================================
//  brightness_ramp_controller_pkg
//  Shared types and helpers for the LED brightness ramp controller.
//   - ramp_state_e   : ramp FSM state encoding (2 bits)
//   - brightness_max : largest value representable in a given bit width
//  Revision: 1.0 - initial release
// ============================================================================
package brightness_ramp_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

  function automatic int brightness_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
//  pwm_generator
//  Free-running PWM with a shadowed duty register. The duty value is only
//  picked up at the start of a period, so a change mid-period never produces
//  a runt or stretched pulse on the LEDs.
//  Ports:
//   clk_i   in   1               system clock
//   rst_i   in   1               reset, asynchronous, active-low
//   duty_i  in   PWM_VALUE_SIZE  requested duty (0 = off, MAX = on)
//   leds_o  out  LED_COUNT       PWM output, all bits identical
//  Revision: 1.0 - initial release
// ============================================================================
module pwm_generator
  import brightness_ramp_controller_pkg::*;
#(
  parameter int PWM_VALUE_SIZE = 8,
  parameter int LED_COUNT      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PWM_VALUE_SIZE-1:0] duty_i,
  output logic [LED_COUNT-1:0]      leds_o
);

  // Counter runs 0..MAX-1, so a period is MAX cycles and a shadow of MAX
  // compares true on every count (constantly on).
  localparam logic [PWM_VALUE_SIZE-1:0] CNT_LAST =
    PWM_VALUE_SIZE'(brightness_max(PWM_VALUE_SIZE) - 1);

  logic [PWM_VALUE_SIZE-1:0] cnt_q, cnt_d;
  logic [PWM_VALUE_SIZE-1:0] shadow_q, shadow_d;

  always_comb begin
    cnt_d    = cnt_q + PWM_VALUE_SIZE'(1);
    shadow_d = shadow_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      shadow_d = duty_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign leds_o = {LED_COUNT{cnt_q < shadow_q}};

endmodule
`default_nettype wire

// File: rtl/brightness_ramp_controller.sv
`default_nettype none
// ============================================================================
//  brightness_ramp_controller
//  Owns the LED brightness target, arbitrates encoder step pulses against an
//  absolute set request, and fades the PWM duty toward the target one LSB
//  per ramp tick.
//  Ports:
//   clk_i        in   1               system clock
//   rst_i        in   1               reset, async assert / sync release, active-low
//   inc_i        in   1               step pulse: target += BRIGHTNESS_INC (saturating)
//   dec_i        in   1               step pulse: target -= BRIGHTNESS_INC (saturating)
//   set_valid_i  in   1               absolute set request
//   set_value_i  in   PWM_VALUE_SIZE  requested target
//   set_ready_o  out  1               high while idle; set accepted on valid & ready
//   target_o     out  PWM_VALUE_SIZE  current target brightness
//   duty_o       out  PWM_VALUE_SIZE  current ramping duty
//   busy_o       out  1               high while a fade is in progress
//   leds_o       out  LED_COUNT       PWM outputs
//  Revision: 1.0 - initial release
// ============================================================================
module brightness_ramp_controller
  import brightness_ramp_controller_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int RAMP_STEP_US   = 10,
  parameter int PWM_VALUE_SIZE = 8,
  parameter int BRIGHTNESS_INC = 10,
  parameter int LED_COUNT      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inc_i,
  input  logic                      dec_i,
  input  logic                      set_valid_i,
  input  logic [PWM_VALUE_SIZE-1:0] set_value_i,
  output logic                      set_ready_o,
  output logic [PWM_VALUE_SIZE-1:0] target_o,
  output logic [PWM_VALUE_SIZE-1:0] duty_o,
  output logic                      busy_o,
  output logic [LED_COUNT-1:0]      leds_o
);

  localparam int W           = PWM_VALUE_SIZE;
  localparam int TICK_CYCLES = CLOCK_FREQ_MHZ * RAMP_STEP_US;
  localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [W:0]        INC_EXT   = (W+1)'(BRIGHTNESS_INC);
  localparam logic [W:0]        MAX_EXT   = (W+1)'(brightness_max(W));

  // Reset synchronizer: assertion propagates immediately, release is
  // aligned to clk_i so no flop sees reset removal near an edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  ramp_state_e       state_q, state_d;
  logic [W-1:0]      target_q, target_d;
  logic [W-1:0]      duty_q, duty_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              busy_q;
  logic              set_accept;
  logic              tick_done;
  logic [W:0]        sum_ext;
  logic [W:0]        diff_ext;

  // Target arbitration: an accepted set wins; inc and dec together cancel.
  // Step arithmetic is one bit wider so overflow/borrow is visible for
  // saturation.
  always_comb begin
    set_accept = set_valid_i && (state_q == IDLE);
    sum_ext    = {1'b0, target_q} + INC_EXT;
    diff_ext   = {1'b0, target_q} - INC_EXT;
    target_d   = target_q;
    if (set_accept) begin
      target_d = set_value_i;
    end else if (inc_i && !dec_i) begin
      target_d = (sum_ext > MAX_EXT) ? MAX_EXT[W-1:0] : sum_ext[W-1:0];
    end else if (dec_i && !inc_i) begin
      target_d = diff_ext[W] ? '0 : diff_ext[W-1:0];
    end
  end

  // Direction is re-derived every cycle from the incoming target so an
  // encoder retarget mid-fade can reverse or stop the ramp. The tick
  // counter keeps running across retargets and is only zeroed while idle.
  always_comb begin
    tick_done = (tick_q == TICK_LAST);
    duty_d    = duty_q;
    tick_d    = tick_q;

    if (target_d > duty_q) begin
      state_d = RAMP_UP;
    end else if (target_d < duty_q) begin
      state_d = RAMP_DOWN;
    end else begin
      state_d = IDLE;
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
      end
      RAMP_UP, RAMP_DOWN: begin
        tick_d = tick_done ? '0 : tick_q + TICK_W'(1);
        // Step guarded against the new target so a same-cycle retarget
        // can never push duty past it.
        if (tick_done) begin
          if ((state_q == RAMP_UP) && (duty_q < target_d)) begin
            duty_d = duty_q + W'(1);
          end else if ((state_q == RAMP_DOWN) && (duty_q > target_d)) begin
            duty_d = duty_q - W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      duty_q   <= '0;
      tick_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      tick_q   <= tick_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign set_ready_o = (state_q == IDLE);
  assign busy_o      = busy_q;
  assign target_o    = target_q;
  assign duty_o      = duty_q;

  pwm_generator #(
    .PWM_VALUE_SIZE (PWM_VALUE_SIZE),
    .LED_COUNT      (LED_COUNT)
  ) u_pwm (
    .clk_i  (clk_i),
    .rst_i  (rst_n),
    .duty_i (duty_q),
    .leds_o (leds_o)
  );

endmodule
`default_nettype wire
